// File: rtl/mult_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_arb_pkg
//  Description : Shared defaults, id-width helper and stage record for the
//                round-robin multiplier scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_arb_pkg;

    localparam int c_def_width = 64;
    localparam int c_def_n_req = 4;
    localparam int c_def_lat   = 2;

    // Requester index width; never narrower than one bit.
    function automatic int id_w_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int c_def_id_w = id_w_of(c_def_n_req);

    // One pipeline slot at the default geometry.
    typedef struct packed {
        logic                   v;
        logic [c_def_id_w-1:0]  id;
        logic [c_def_width-1:0] a;
        logic [c_def_width-1:0] b;
    } stage_t;

endpackage
`default_nettype wire

// File: rtl/mult_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_arb_if
//  Description : Requester and response channels of the shared multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mult_arb_if
    import mult_arb_pkg::*;
#(
    parameter int WIDTH = c_def_width,
    parameter int N_REQ = c_def_n_req,
    parameter int ID_W  = id_w_of(N_REQ)
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [WIDTH-1:0]       rsp_data;
    logic [ID_W-1:0]        rsp_id;

    // Requesters and the response consumer.
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    // The scheduler itself.
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface
`default_nettype wire

// File: rtl/mult_arb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker: first request at or after
//                ptr, wrapping. Pointer storage lives in the caller.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = id_w_of(N)
) (
    input  wire logic [N-1:0]    req,
    input  wire logic [ID_W-1:0] ptr,
    output logic      [N-1:0]    gnt,
    output logic      [ID_W-1:0] gnt_id
);

    logic w_found;
    int   w_idx;

    // Scan N positions starting at ptr; the first asserted request wins.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(ptr) + k) % N;
            if (!w_found && req[w_idx]) begin
                w_found     = 1'b1;
                gnt[w_idx]  = 1'b1;
                gnt_id      = ID_W'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mult_arb
//  Description : Round-robin scheduler sharing one pipelined WIDTHxWIDTH
//                multiplier among N_REQ requesters; truncated product is
//                returned tagged with the owner's index.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_arb
    import mult_arb_pkg::*;
#(
    parameter int WIDTH = c_def_width,
    parameter int N_REQ = c_def_n_req,
    parameter int LAT   = c_def_lat
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    mult_arb_if.slave   bus
);

    localparam int c_id_w = id_w_of(N_REQ);

    logic [N_REQ-1:0]  w_gnt;
    logic [c_id_w-1:0] w_gnt_id;
    logic [c_id_w-1:0] r_ptr;
    logic              w_adv;
    logic              w_xfer;
    logic [WIDTH-1:0]  w_a;
    logic [WIDTH-1:0]  w_b;
    logic [WIDTH-1:0]  w_prod;

    // The product is formed at acceptance, so every stage carries {v, id, p}.
    logic              r_v  [LAT];
    logic [c_id_w-1:0] r_id [LAT];
    logic [WIDTH-1:0]  r_d  [LAT];

    rr_arbiter #(
        .N    (N_REQ),
        .ID_W (c_id_w)
    ) u_arb (
        .req    (bus.req_valid),
        .ptr    (r_ptr),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id)
    );

    // Whole pipeline moves unless the last stage holds an unconsumed product.
    assign w_adv         = ~(r_v[LAT-1] & ~bus.rsp_ready);
    // Reset gating keeps req_ready low for the whole time rst_n is asserted.
    assign bus.req_ready = w_gnt & {N_REQ{w_adv & rst_n}};
    assign w_xfer        = |bus.req_ready;

    // One-hot operand select from the granted requester.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_a = bus.req_a[i*WIDTH +: WIDTH];
                w_b = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_prod = w_a * w_b;

    // Pointer moves just past the requester that transferred.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= (w_gnt_id == c_id_w'(N_REQ-1)) ? '0 : w_gnt_id + c_id_w'(1);
        end
    end

    // Shift the pipeline on advance; no transfer inserts a bubble at stage 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < LAT; s++) begin
                r_v[s]  <= 1'b0;
                r_id[s] <= '0;
                r_d[s]  <= '0;
            end
        end else if (w_adv) begin
            r_v[0]  <= w_xfer;
            r_id[0] <= w_gnt_id;
            r_d[0]  <= w_prod;
            for (int s = 1; s < LAT; s++) begin
                r_v[s]  <= r_v[s-1];
                r_id[s] <= r_id[s-1];
                r_d[s]  <= r_d[s-1];
            end
        end
    end

    assign bus.rsp_valid = r_v[LAT-1];
    assign bus.rsp_data  = r_d[LAT-1];
    assign bus.rsp_id    = r_id[LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_mult_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_arb
//  Description : Self-checking bench for mult_arb with a slot-level reference
//                model and a response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_arb;

    localparam int W = 64;
    localparam int N = 4;
    localparam int L = 2;

    typedef struct {
        int          id;
        logic [W-1:0] d;
    } exp_t;

    logic clk;
    logic rst_n;

    mult_arb_if #(.WIDTH(W), .N_REQ(N)) bus ();

    mult_arb #(
        .WIDTH (W),
        .N_REQ (N),
        .LAT   (L)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_in  = 0;
    int n_out = 0;

    // Reference: next-search position and the content of each output slot.
    int           m_ptr;
    logic         m_v  [L];
    int           m_id [L];
    logic [W-1:0] m_d  [L];
    exp_t         sb[$];
    int           last_grant;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_ptr = 0;
        for (int s = 0; s < L; s++) begin
            m_v[s]  = 1'b0;
            m_id[s] = 0;
            m_d[s]  = '0;
        end
        sb.delete();
    endtask

    function automatic int model_grant();
        if (m_v[L-1] && !bus.rsp_ready) return -1;
        for (int k = 0; k < N; k++) begin
            if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // Called at posedge+1 with inputs settled; checks, then advances one clock.
    task automatic step();
        int           g;
        logic [W-1:0] a;
        logic [W-1:0] b;
        exp_t         e;
        @(negedge clk);
        g = model_grant();
        chk("req_ready", 64'(bus.req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_v[L-1]));
        if (m_v[L-1]) begin
            chk("rsp_id", 64'(bus.rsp_id), 64'(m_id[L-1]));
            chk("rsp_data", bus.rsp_data, m_d[L-1]);
        end
        last_grant = g;
        @(posedge clk);
        if (!(m_v[L-1] && !bus.rsp_ready)) begin
            for (int s = L-1; s > 0; s--) begin
                m_v[s]  = m_v[s-1];
                m_id[s] = m_id[s-1];
                m_d[s]  = m_d[s-1];
            end
            m_v[0] = (g >= 0);
            if (g >= 0) begin
                a       = bus.req_a[g*W +: W];
                b       = bus.req_b[g*W +: W];
                m_id[0] = g;
                m_d[0]  = a * b;
                e.id    = g;
                e.d     = a * b;
                sb.push_back(e);
                n_in++;
                m_ptr   = (g + 1) % N;
            end
        end
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
    endtask

    task automatic idle(input int n);
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    // Scoreboard monitor: every consumed response must match the oldest issue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got id %0d data %0h expected nothing", bus.rsp_id, bus.rsp_data);
            end else begin
                e = sb.pop_front();
                chk("sb_id", 64'(bus.rsp_id), 64'(e.id));
                chk("sb_data", bus.rsp_data, e.d);
                n_out++;
            end
        end
    end

    initial begin
        int seen [6];
        model_clear();
        last_grant    = -1;
        rst_n         = 1'b0;
        bus.req_valid = '1;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;

        // Reset state, with requests pending.
        #12;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_data", bus.rsp_data, 64'd0);
        chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fairness: all valid from a fresh pointer.
        bus.req_valid = '1;
        for (int i = 0; i < N; i++) set_op(i, W'(i + 10), W'(i + 2));
        for (int i = 0; i < 6; i++) begin
            step();
            seen[i] = last_grant;
        end
        for (int i = 0; i < 6; i++) chk("fair_order", 64'(seen[i]), 64'(i % N));
        idle(4);

        // Single shot from requester 2: 3*7, visible two cycles after acceptance.
        bus.req_valid = 4'b0100;
        set_op(2, 64'd3, 64'd7);
        step();
        bus.req_valid = '0;
        chk("shot_early", 64'(bus.rsp_valid), 64'd0);
        step();
        chk("shot_valid", 64'(bus.rsp_valid), 64'd1);
        chk("shot_data", bus.rsp_data, 64'd21);
        chk("shot_id", 64'(bus.rsp_id), 64'd2);
        idle(3);

        // Truncation corner cases.
        bus.req_valid = 4'b0001;
        set_op(0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001);
        step();
        bus.req_valid = '0;
        step();
        chk("wrap_data", bus.rsp_data, 64'd1);
        bus.req_valid = 4'b0001;
        set_op(0, 64'h1_0000_0000, 64'h1_0000_0000);
        step();
        bus.req_valid = '0;
        step();
        chk("zero_data", bus.rsp_data, 64'd0);
        idle(3);

        // Backpressure mid-stream from requester 1.
        bus.req_valid = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            set_op(1, {$urandom, $urandom}, {$urandom, $urandom});
            bus.rsp_ready = !(i >= 3 && i < 6);
            step();
        end
        idle(4);

        // Pointer hold on requester 3, then wrap to 0.
        bus.req_valid = 4'b1000;
        set_op(3, 64'd5, 64'd9);
        step();
        chk("hold_g0", 64'(last_grant), 64'd3);
        step();
        chk("hold_g1", 64'(last_grant), 64'd3);
        bus.req_valid = 4'b1001;
        set_op(0, 64'd4, 64'd4);
        step();
        chk("hold_wrap", 64'(last_grant), 64'd0);
        idle(4);

        // Randomised traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            bus.req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) set_op(i, {$urandom, $urandom}, {$urandom, $urandom});
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        idle(6);
        chk("drain_empty", 64'(sb.size()), 64'd0);
        chk("count_in_out", 64'(n_out), 64'(n_in));

        // Reset mid-flight with two products in the pipe.
        bus.req_valid = 4'b0110;
        set_op(1, 64'd11, 64'd13);
        set_op(2, 64'd17, 64'd19);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("midrst_req_ready", 64'(bus.req_ready), 64'd0);
        model_clear();
        bus.req_valid = '0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(4);
        bus.req_valid = 4'b1010;
        set_op(1, 64'd6, 64'd7);
        set_op(3, 64'd8, 64'd9);
        step();
        chk("postrst_grant", 64'(last_grant), 64'd1);
        idle(5);
        chk("final_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_arb.md
# mult_arb

Round-robin scheduler that shares one pipelined WIDTH×WIDTH multiplier among N_REQ requesters in the non-linear-op datapath (exp/sigmoid/GELU polynomial units). Each requester issues operand pairs over a valid/ready channel. The block arbitrates, pushes one product per cycle through a LAT-stage pipeline, and returns the truncated product tagged with the requester index on a single backpressured response channel.

## Interface
- WIDTH, 64: operand and product width; product is the low WIDTH bits.
- N_REQ, 4: number of requesters, 2..16.
- LAT, 2: pipeline depth in cycles from accept to rsp_valid, 1..4.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit set per cycle.
- req_a  in  N_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  operand B, same packing as req_a.
- rsp_valid  out  1  product valid.
- rsp_ready  in  1  consumer accept.
- rsp_data  out  WIDTH  (a*b) mod 2^WIDTH, unsigned.
- rsp_id  out  ID_W=$clog2(N_REQ)  index of the requester that owns rsp_data.

## Operation
- Arbitration: round-robin over req_valid, starting the search at pointer ptr.
  - grant = first set bit at or after ptr, wrapping around.
  - req_ready[i] = grant[i] & adv.
- Transfer: a transfer occurs when req_valid[i] & req_ready[i].
  - On transfer, ptr <= (i+1) mod N_REQ.
  - With no transfer, ptr holds.
- Pipeline: LAT stages, each holding {v, id, a, b or partial product}.
  - The team's combinational multiplier core computes the product.
  - Register placement is free as long as total latency is LAT.
- Stall: adv = ~(stage_LAT.v & ~rsp_ready). If adv=0, every stage holds and req_ready is all-zero.
- Bubbles: a cycle with no transfer inserts v=0 into stage 1. Bubbles are not collapsed.
- Output: rsp_valid/rsp_data/rsp_id come straight from the last stage registers.
  - Data and id stay stable while rsp_valid & ~rsp_ready.
- Requesters: req_valid may rise or drop at any time without a transfer. There is no request-hold obligation on requesters.
- Ordering: responses leave in acceptance order. Per-requester order is preserved.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert handled upstream):
  - All stage valid bits, rsp_valid, rsp_data, rsp_id and ptr clear to 0.
  - req_ready is 0 while rst_n=0.
- Latency: a transfer at edge t gives rsp_valid=1 after edge t+LAT-1, so it is visible in the LAT-th cycle, provided no stall occurs.
- Throughput: 1 product/cycle with rsp_ready held high.
- Stall: each stall cycle adds exactly one cycle to every in-flight operation.
- Simultaneous events: when the output is consumed and a new request is accepted in the same cycle, both happen (adv=1).
- Reset mid-operation: in-flight products are dropped and no response is produced for them. The first grant after reset starts from requester 0.
- Fairness: with all requesters valid, grants rotate 0,1,...,N_REQ-1,0,...

## Structure
- Package mult_arb_pkg holds:
  - default WIDTH/N_REQ/LAT constants;
  - ID_W derivation;
  - stage_t packed struct {v, id, a, b}.
- Sub-module rr_arbiter(N): purely combinational.
  - Inputs: req[N], ptr.
  - Outputs: one-hot gnt[N] and encoded gnt_id.
  - ptr update stays in mult_arb.

## Test plan
- Single shot: N_REQ=4, LAT=2, req 2 sends a=3, b=7. Expect rsp_valid exactly 2 cycles later with rsp_data=21, rsp_id=2.
- Fairness: all 4 requesters valid continuously, rsp_ready=1.
  - Expect grant order 0,1,2,3,0,1.
  - Expect rsp_id sequence 0,1,2,3 on consecutive cycles starting at cycle LAT.
- Wrap/truncation: WIDTH=64, a=b=2^63+1. Expect rsp_data=2^64+1 mod 2^64... low 64 bits = 1. For a=2^32, b=2^32 expect rsp_data=0.
- Backpressure: stream from req 1, rsp_ready low for 3 cycles mid-stream.
  - Expect req_ready=0 during the stall and rsp_data/rsp_id frozen.
  - Expect no loss or duplication; count in equals count out.
- Pointer hold: only req 3 valid. Expect back-to-back grants to 3. Then req 0 and 3 both valid: expect the next grant to go to 0 (ptr=0 after wrap).
- Reset mid-flight: 2 ops in the pipe, pulse rst_n low asynchronously between edges.
  - Expect rsp_valid=0 immediately.
  - Expect no stale response afterwards.
  - Expect first post-reset grant to go to the lowest valid index.
